// File: rtl/mac_kern_pkg.sv
// rtl/mac_kern_pkg.sv - shared defaults, width helpers and pipeline sideband type for mac_kern_multi
package mac_kern_pkg;

  localparam int WI_DEF       = 8;
  localparam int N_DEF        = 16;
  localparam int MAX_TAPS_DEF = 25;

  localparam int TAPS_1X1 = 1;
  localparam int TAPS_3X3 = 9;
  localparam int TAPS_5X5 = 25;

  function automatic int dp_width(input int wi, input int n);
    return 2 * wi + $clog2(n);
  endfunction

  function automatic int out_width(input int wi, input int n, input int max_taps);
    return dp_width(wi, n) + $clog2(max_taps);
  endfunction

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } sband_t;

endpackage

// File: rtl/dot_prod_n.sv
// rtl/dot_prod_n.sv - N-lane signed multiply and registered adder tree, latency WN+1 enabled cycles
module dot_prod_n
  import mac_kern_pkg::*;
#(
  parameter int WI = WI_DEF,
  parameter int N  = N_DEF,
  parameter int WN = $clog2(N),
  parameter int WP = 2 * WI + WN
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic [N*WI-1:0]      w_i,
  input  logic [N*WI-1:0]      d_i,
  input  sband_t               sb_i,
  output logic signed [WP-1:0] dp_o,
  output sband_t               sb_o,
  output logic                 busy_o
);

  localparam int NP = 1 << WN;

  logic signed [2*WI-1:0] wx [N];
  logic signed [2*WI-1:0] dx [N];
  logic signed [2*WI-1:0] prod_q [NP];
  sband_t                 sb_q [WN+1];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      wx[k] = (2*WI)'($signed(w_i[k*WI +: WI]));
      dx[k] = (2*WI)'($signed(d_i[k*WI +: WI]));
    end
  end

  // Padding lanes up to a power of two stay zero so the tree is always balanced.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NP; k++) prod_q[k] <= '0;
      for (int l = 0; l <= WN; l++) sb_q[l] <= '0;
    end else if (en_i) begin
      for (int k = 0; k < N; k++) prod_q[k] <= wx[k] * dx[k];
      for (int k = N; k < NP; k++) prod_q[k] <= '0;
      sb_q[0] <= sb_i;
      for (int l = 1; l <= WN; l++) sb_q[l] <= sb_q[l-1];
    end
  end

  for (genvar l = 1; l <= WN; l++) begin : g_lvl
    for (genvar k = 0; k < (NP >> l); k++) begin : g_node
      logic signed [2*WI+l-1:0] s_q;
      logic signed [2*WI+l-2:0] a;
      logic signed [2*WI+l-2:0] b;
      if (l == 1) begin : g_leaf
        assign a = prod_q[2*k];
        assign b = prod_q[2*k+1];
      end else begin : g_inner
        assign a = g_lvl[l-1].g_node[2*k].s_q;
        assign b = g_lvl[l-1].g_node[2*k+1].s_q;
      end
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s_q <= '0;
        else if (en_i) s_q <= (2*WI+l)'(a) + (2*WI+l)'(b);
      end
    end
  end

  assign dp_o = g_lvl[WN].g_node[0].s_q;
  assign sb_o = sb_q[WN];

  always_comb begin
    busy_o = 1'b0;
    for (int l = 0; l <= WN; l++) busy_o = busy_o | sb_q[l].vld;
  end

endmodule

// File: rtl/mac_kern_multi.sv
// rtl/mac_kern_multi.sv - runtime-configurable tap accumulator over an N-lane dot product
// Optional: define MAC_KERN_MULTI_RELU_EN to clamp negative group sums to zero on output.
module mac_kern_multi
  import mac_kern_pkg::*;
#(
  parameter int WI       = WI_DEF,
  parameter int N        = N_DEF,
  parameter int MAX_TAPS = MAX_TAPS_DEF,
  parameter int WN       = $clog2(N),
  parameter int WT       = $clog2(MAX_TAPS + 1),
  parameter int WP       = dp_width(WI, N),
  parameter int WO       = out_width(WI, N, MAX_TAPS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WT-1:0]        cfg_taps,
  input  logic                 vld_i,
  output logic                 rdy_o,
  input  logic [N*WI-1:0]      win,
  input  logic [N*WI-1:0]      din,
  output logic signed [WO-1:0] acc_o,
  output logic                 vld_o,
  input  logic                 rdy_i,
  output logic                 busy_o
);

  logic                 stall, en, take;
  logic [WT-1:0]        in_cnt_q, in_cnt_d, taps_q, taps_d, taps_live, taps_cur;
  logic                 beat_first, beat_last;
  sband_t               sb_in, sb_dp;
  logic signed [WP-1:0] dp;
  logic                 pipe_busy;
  logic signed [WO-1:0] dp_ext, sum, result;
  logic signed [WO-1:0] psum_q, psum_d, acc_q, acc_d;
  logic                 vld_q, vld_d;

  // Input side: the first beat of a group sees the live tap count, later beats the latched one.
  always_comb begin
    stall      = vld_q & ~rdy_i;
    en         = ~stall;
    take       = vld_i & en;
    taps_live  = (cfg_taps == '0) ? WT'(TAPS_1X1) : cfg_taps;
    beat_first = (in_cnt_q == '0);
    taps_cur   = beat_first ? taps_live : taps_q;
    beat_last  = (in_cnt_q == taps_cur - WT'(1));
    in_cnt_d   = in_cnt_q;
    taps_d     = taps_q;
    if (take) begin
      if (beat_first) taps_d = taps_live;
      in_cnt_d = beat_last ? '0 : in_cnt_q + WT'(1);
    end
    sb_in.vld   = take;
    sb_in.first = take & beat_first;
    sb_in.last  = take & beat_last;
  end

  dot_prod_n #(
    .WI (WI),
    .N  (N),
    .WN (WN),
    .WP (WP)
  ) u_dot (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (en),
    .w_i    (win),
    .d_i    (din),
    .sb_i   (sb_in),
    .dp_o   (dp),
    .sb_o   (sb_dp),
    .busy_o (pipe_busy)
  );

  always_comb begin
    dp_ext = WO'(dp);
    sum    = sb_dp.first ? dp_ext : psum_q + dp_ext;
`ifdef MAC_KERN_MULTI_RELU_EN
    result = sum[WO-1] ? '0 : sum;
`else
    result = sum;
`endif
    psum_d = psum_q;
    acc_d  = acc_q;
    vld_d  = vld_q;
    if (vld_q & rdy_i) vld_d = 1'b0;
    if (en & sb_dp.vld) begin
      psum_d = sum;
      if (sb_dp.last) begin
        acc_d = result;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt_q <= '0;
      taps_q   <= WT'(TAPS_1X1);
      psum_q   <= '0;
      acc_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      in_cnt_q <= in_cnt_d;
      taps_q   <= taps_d;
      psum_q   <= psum_d;
      acc_q    <= acc_d;
      vld_q    <= vld_d;
    end
  end

  assign rdy_o  = ~stall;
  assign acc_o  = acc_q;
  assign vld_o  = vld_q;
  assign busy_o = (in_cnt_q != '0) | pipe_busy | vld_q;

endmodule

// File: tb/tb_mac_kern_multi.sv
// tb/tb_mac_kern_multi.sv - self-checking bench for mac_kern_multi against a group-sum reference model
module tb_mac_kern_multi;

  localparam int WI       = 8;
  localparam int N        = 16;
  localparam int MAX_TAPS = 25;
  localparam int WN       = $clog2(N);
  localparam int WT       = $clog2(MAX_TAPS + 1);
  localparam int WO       = 2 * WI + WN + $clog2(MAX_TAPS);

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [WT-1:0]        cfg_taps;
  logic                 vld_i;
  logic                 rdy_o;
  logic [N*WI-1:0]      win, din;
  logic signed [WO-1:0] acc_o;
  logic                 vld_o;
  logic                 rdy_i = 1'b1;
  logic                 busy_o;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  bit     rdy_hold = 1'b1;
  bit     rand_bp  = 1'b0;
  longint exp_q[$];
  longint got_q[$];
  int     got_cyc_q[$];

  mac_kern_multi dut (
    .clk      (clk),
    .rstn     (rstn),
    .cfg_taps (cfg_taps),
    .vld_i    (vld_i),
    .rdy_o    (rdy_o),
    .win      (win),
    .din      (din),
    .acc_o    (acc_o),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rdy_i = rand_bp ? ($urandom_range(0, 3) != 0) : rdy_hold;
  end

  always @(negedge clk) begin
    if (rstn && vld_o && rdy_i) begin
      got_q.push_back(longint'(acc_o));
      got_cyc_q.push_back(cyc);
    end
  end

  function automatic longint exp_of(input longint s);
`ifdef MAC_KERN_MULTI_RELU_EN
    return (s < 0) ? 0 : s;
`else
    return s;
`endif
  endfunction

  task automatic drive_beat(input logic [N*WI-1:0] w, input logic [N*WI-1:0] d);
    int   g = 0;
    logic took = 1'b0;
    vld_i = 1'b1;
    win   = w;
    din   = d;
    while (!took && g < 200) begin
      @(negedge clk);
      took = rdy_o;
      @(posedge clk);
      #1;
      g++;
    end
    vld_i = 1'b0;
    if (!took) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: rdy_o stayed 0 for %0d cycles, required 1", g);
    end
  endtask

  // mode 0: every lane w=a d=b; mode 1: w=a d=lane index; otherwise random operands.
  task automatic send_group(input int taps, input int mode, input int a, input int b);
    int              eff;
    int              wk, dk;
    longint          s;
    logic [N*WI-1:0] wv, dv;
    eff = (taps == 0) ? 1 : taps;
    s   = 0;
    for (int i = 0; i < eff; i++) begin
      for (int k = 0; k < N; k++) begin
        case (mode)
          0:       begin wk = a; dk = b; end
          1:       begin wk = a; dk = k; end
          default: begin
            wk = int'($urandom_range(0, 255)) - 128;
            dk = int'($urandom_range(0, 255)) - 128;
          end
        endcase
        wv[k*WI +: WI] = wk[WI-1:0];
        dv[k*WI +: WI] = dk[WI-1:0];
        s += longint'(wk * dk);
      end
      cfg_taps = (i == 0) ? WT'(taps) : WT'($urandom_range(0, MAX_TAPS));
      drive_beat(wv, dv);
    end
    exp_q.push_back(exp_of(s));
  endtask

  task automatic wait_drain(output bit ok);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((got_q.size() < exp_q.size() || busy_o) && g < 3000);
    ok = !(got_q.size() < exp_q.size() || busy_o);
  endtask

  task automatic test_reset();
    rstn = 1'b0; vld_i = 1'b0; win = '0; din = '0; cfg_taps = WT'(1);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (acc_o !== '0) begin n_fail++; $display("FAIL reset_acc_o: got %0d want 0", acc_o); end
    n_checks++; if (vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld_o: got %0b want 0", vld_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_o: got %0b want 0", busy_o); end
    n_checks++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_o: got %0b want 1", rdy_o); end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0 || vld_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: busy_o=%0b vld_o=%0b want 0 0", busy_o, vld_o);
    end
  endtask

  task automatic test_taps1();
    bit ok;
    int t0;
    longint e, g;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) send_group(1, 0, 2, 3);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != 4) begin
      n_fail++; $display("FAIL taps1_count: got %0d results want 4", got_q.size());
    end else begin
      n_checks++; if (got_cyc_q[0] - t0 != WN + 2) begin
        n_fail++; $display("FAIL taps1_latency: got %0d cycles want %0d", got_cyc_q[0] - t0, WN + 2);
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++; if (got_cyc_q[i] - got_cyc_q[i-1] != 1) begin
          n_fail++; $display("FAIL taps1_throughput: result %0d gap %0d want 1", i, got_cyc_q[i] - got_cyc_q[i-1]);
        end
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL taps1_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_taps9();
    bit ok;
    int t_last;
    longint e, g;
    @(posedge clk); #1;
    send_group(9, 1, 1, 0);
    t_last = cyc;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL taps9_busy: got %0b want 1", busy_o); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL taps9_early: got %0d results want 0", got_q.size()); end
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != 1) begin
      n_fail++; $display("FAIL taps9_count: got %0d results want 1", got_q.size());
    end else begin
      n_checks++; if (got_cyc_q[0] - t_last != WN + 1) begin
        n_fail++; $display("FAIL taps9_latency: got %0d want %0d", got_cyc_q[0] - t_last, WN + 1);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL taps9_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    longint e, g;
    @(posedge clk); #1;
    send_group(9, 0, -1, 1);
    send_group(25, 0, -1, 1);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 2", got_q.size());
    end else begin
      n_checks++; if (got_cyc_q[1] - got_cyc_q[0] != 25) begin
        n_fail++; $display("FAIL b2b_gap: got %0d cycles want 25", got_cyc_q[1] - got_cyc_q[0]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_stall();
    bit ok;
    int w;
    longint held, e, g;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_group(1, 0, 1, i + 1);
      end
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!vld_o && w < 100);
        rdy_hold = 1'b0;
        @(posedge clk); #2;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          n_checks++; if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL stall_rdy_o: cycle %0d got %0b want 0", c, rdy_o); end
          if (c == 0) held = longint'(acc_o);
          else begin
            n_checks++; if (longint'(acc_o) !== held) begin
              n_fail++; $display("FAIL stall_acc_hold: cycle %0d got %0d want %0d", c, acc_o, held);
            end
          end
        end
        rdy_hold = 1'b1;
      end
    join
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != 8) begin
      n_fail++; $display("FAIL stall_count: got %0d results want 8", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL stall_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_extreme_and_relu();
    bit ok;
    longint e, g;
    @(posedge clk); #1;
    send_group(25, 0, -128, -128);
    send_group(1, 0, -1, 5);
    send_group(0, 0, 3, -2);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != 3) begin
      n_fail++; $display("FAIL extreme_count: got %0d results want 3", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL extreme_relu_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_reset_mid_group();
    bit ok;
    longint e, g;
    @(posedge clk); #1;
    cfg_taps = WT'(9);
    for (int i = 0; i < 4; i++) drive_beat({N*WI/32{$urandom}}, {N*WI/32{$urandom}});
    rstn = 1'b0;
    #1;
    n_checks++; if (vld_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: vld_o=%0b busy_o=%0b want 0 0", vld_o, busy_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_ghost: got %0d results want 0", got_q.size()); end
    @(posedge clk); #1;
    send_group(9, 2, 0, 0);
    wait_drain(ok);
    n_checks++; if (!ok || got_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_count: got %0d results want 1", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL midrst_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    longint e, g;
    @(posedge clk); #1;
    rand_bp = 1'b1;
    for (int i = 0; i < 10; i++) send_group(int'($urandom_range(0, MAX_TAPS)), 2, 0, 0);
    wait_drain(ok);
    rand_bp = 1'b0;
    n_checks++; if (!ok || got_q.size() != 10) begin
      n_fail++; $display("FAIL random_count: got %0d results want 10", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL random_value: got %0d want %0d", g, e); end
    end
    exp_q.delete(); got_q.delete(); got_cyc_q.delete();
  endtask

  initial begin
    test_reset();
    test_taps1();
    test_taps9();
    test_back_to_back();
    test_stall();
    test_extreme_and_relu();
    test_reset_mid_group();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
